// File: rtl/cga_alu_muldiv_pkg.sv
// Shared types and constants for the RALU multiply/divide sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cga_alu_muldiv_pkg;

   localparam int MD_WIDTH = 16;
   localparam int MD_CNT_W = 5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   // RALU control vector, msb first: RSN, ALUI4, CI, LOG, FSEL
   typedef struct packed {
      logic rsn;
      logic alui4;
      logic ci;
      logic lgc;
      logic fsel;
   } ralu_ctl_t;

   // R+S
   localparam ralu_ctl_t RALU_ADD = ralu_ctl_t'(5'b00000);
   // S-R (S + ~R + 1); carry out high means no borrow
   localparam ralu_ctl_t RALU_SUB = ralu_ctl_t'(5'b10100);

endpackage

// File: rtl/cga_alu_muldiv_step.sv
// One multiply or divide iteration: RALU operand select and next A/Q.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, the top decides when to commit.
module cga_alu_muldiv_step
   import cga_alu_muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] m,
   input  logic [WIDTH-1:0] f,
   input  logic             cry,
   output logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] a_nxt,
   output logic [WIDTH-1:0] q_nxt
);

   logic [WIDTH-1:0] ash;

   // Shift-add multiply or restoring divide; a[msb] and cry extend each pass to 17 bits
   always_comb begin
      ash   = {a[WIDTH-2:0], q[WIDTH-1]};
      r     = '0;
      s     = a;
      a_nxt = a;
      q_nxt = q;
      if (op == OP_MUL) begin
         r     = q[0] ? m : '0;
         s     = a;
         a_nxt = {cry, f[WIDTH-1:1]};
         q_nxt = {f[0], q[WIDTH-1:1]};
      end else begin
         r = m;
         s = ash;
         if (a[WIDTH-1] | cry) begin
            a_nxt = f;
            q_nxt = {q[WIDTH-2:0], 1'b1};
         end else begin
            a_nxt = ash;
            q_nxt = {q[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/cga_alu_muldiv_seq.sv
// Sequencer for unsigned 16x16 multiply and 32/16 divide, one RALU pass per clock.
// Latency: MUL 17, DIV 18, DIV error 2 cycles from the START edge to DONE.
// Backpressure: START honoured only in IDLE; ignored while BUSY and in the DONE cycle.
module cga_alu_muldiv_seq
   import cga_alu_muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int CNT_W = MD_CNT_W
) (
   input  logic             sysclk,
   input  logic             sys_rst_n,
   input  logic             START,
   input  logic             OP,
   input  logic [WIDTH-1:0] OPH_15_0,
   input  logic [WIDTH-1:0] OPL_15_0,
   input  logic [WIDTH-1:0] OPM_15_0,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR,
   output logic [WIDTH-1:0] RES_HI_15_0,
   output logic [WIDTH-1:0] RES_LO_15_0,
   output logic [WIDTH-1:0] RALU_RN_15_0,
   output logic [WIDTH-1:0] RALU_S_15_0,
   output logic             RALU_RSN,
   output logic             RALU_ALUI4,
   output logic             RALU_CI,
   output logic             RALU_LOG,
   output logic             RALU_FSEL,
   input  logic [WIDTH-1:0] RALU_F_15_0,
   input  logic             RALU_CRY
);

   state_t           state;
   logic [WIDTH-1:0] a_reg, q_reg, m_reg;
   logic [CNT_W-1:0] cnt;
   logic             op_reg, busy_reg, done_reg, err_reg;

   logic [WIDTH-1:0] step_r, step_s, a_nxt, q_nxt;
   ralu_ctl_t        ctl;

   cga_alu_muldiv_step #(.WIDTH(WIDTH)) u_step (
      .op    (op_reg),
      .a     (a_reg),
      .q     (q_reg),
      .m     (m_reg),
      .f     (RALU_F_15_0),
      .cry   (RALU_CRY),
      .r     (step_r),
      .s     (step_s),
      .a_nxt (a_nxt),
      .q_nxt (q_nxt)
   );

   // RALU drive from state; outside CHECK/RUN the RALU idles as A + 0
   always_comb begin
      ctl          = RALU_ADD;
      RALU_RN_15_0 = '1;
      RALU_S_15_0  = a_reg;
      case (state)
         S_CHECK: begin
            ctl          = RALU_SUB;
            RALU_RN_15_0 = ~m_reg;
            RALU_S_15_0  = a_reg;
         end
         S_RUN: begin
            ctl          = (op_reg == OP_DIV) ? RALU_SUB : RALU_ADD;
            RALU_RN_15_0 = ~step_r;
            RALU_S_15_0  = step_s;
         end
         default: ;
      endcase
   end

   assign RALU_RSN    = ctl.rsn;
   assign RALU_ALUI4  = ctl.alui4;
   assign RALU_CI     = ctl.ci;
   assign RALU_LOG    = ctl.lgc;
   assign RALU_FSEL   = ctl.fsel;
   assign BUSY        = busy_reg;
   assign DONE        = done_reg;
   assign ERR         = err_reg;
   assign RES_HI_15_0 = a_reg;
   assign RES_LO_15_0 = q_reg;

   // Control FSM and partial-result registers with registered BUSY/DONE/ERR
   always_ff @(posedge sysclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= S_IDLE;
         a_reg    <= '0;
         q_reg    <= '0;
         m_reg    <= '0;
         cnt      <= '0;
         op_reg   <= OP_MUL;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (START) begin
                  m_reg    <= OPM_15_0;
                  q_reg    <= OPL_15_0;
                  a_reg    <= (OP == OP_DIV) ? OPH_15_0 : '0;
                  cnt      <= '0;
                  op_reg   <= OP;
                  err_reg  <= 1'b0;
                  busy_reg <= 1'b1;
                  state    <= (OP == OP_DIV) ? S_CHECK : S_RUN;
               end
            end
            S_CHECK: begin
               // High word >= divisor (includes divisor 0): quotient cannot fit
               if (RALU_CRY) begin
                  err_reg  <= 1'b1;
                  busy_reg <= 1'b0;
                  done_reg <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               a_reg <= a_nxt;
               q_reg <= q_nxt;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  busy_reg <= 1'b0;
                  done_reg <= 1'b1;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               done_reg <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cga_alu_muldiv_seq.sv
// Directed bench for the multiply/divide sequencer with a behavioural RALU.
// Latency: checks DONE arrival cycle per operation.
// Backpressure: exercises START ignored mid-RUN and in the DONE cycle.
module tb_cga_alu_muldiv_seq;

   logic        sysclk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        START = 1'b0;
   logic        OP = 1'b0;
   logic [15:0] OPH_15_0 = '0, OPL_15_0 = '0, OPM_15_0 = '0;
   logic        BUSY, DONE, ERR;
   logic [15:0] RES_HI_15_0, RES_LO_15_0, RALU_RN_15_0, RALU_S_15_0;
   logic        RALU_RSN, RALU_ALUI4, RALU_CI, RALU_LOG, RALU_FSEL;
   logic [15:0] RALU_F_15_0;
   logic        RALU_CRY;

   int          n_assert = 0;
   int          n_fail = 0;
   bit          chk_valid = 1'b0;
   logic [15:0] exp_hi = '0, exp_lo = '0;
   logic        exp_err = 1'b0;

   cga_alu_muldiv_seq dut (
      .sysclk       (sysclk),
      .sys_rst_n    (sys_rst_n),
      .START        (START),
      .OP           (OP),
      .OPH_15_0     (OPH_15_0),
      .OPL_15_0     (OPL_15_0),
      .OPM_15_0     (OPM_15_0),
      .BUSY         (BUSY),
      .DONE         (DONE),
      .ERR          (ERR),
      .RES_HI_15_0  (RES_HI_15_0),
      .RES_LO_15_0  (RES_LO_15_0),
      .RALU_RN_15_0 (RALU_RN_15_0),
      .RALU_S_15_0  (RALU_S_15_0),
      .RALU_RSN     (RALU_RSN),
      .RALU_ALUI4   (RALU_ALUI4),
      .RALU_CI      (RALU_CI),
      .RALU_LOG     (RALU_LOG),
      .RALU_FSEL    (RALU_FSEL),
      .RALU_F_15_0  (RALU_F_15_0),
      .RALU_CRY     (RALU_CRY)
   );

   always #5 sysclk = ~sysclk;

   // Arithmetic RALU: R = ~RN, RSN selects ~R (i.e. RN) for subtraction
   logic [15:0] ralu_rop;
   logic [16:0] ralu_sum;
   always_comb begin
      ralu_rop    = RALU_RSN ? RALU_RN_15_0 : ~RALU_RN_15_0;
      ralu_sum    = {1'b0, ralu_rop} + {1'b0, RALU_S_15_0} + {16'h0, RALU_CI};
      RALU_F_15_0 = ralu_sum[15:0];
      RALU_CRY    = ralu_sum[16];
   end

   // Expected {err, hi, lo} from plain arithmetic
   function automatic logic [32:0] model(input logic op, input logic [15:0] h, l, m);
      logic [31:0] p, d;
      if (op == 1'b0) begin
         p = {16'h0, m} * {16'h0, l};
         return {1'b0, p};
      end
      if (m == 16'h0 || h >= m) return {1'b1, h, l};
      d = {h, l};
      return {1'b0, 16'(d % {16'h0, m}), 16'(d / {16'h0, m})};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-cycle check: DONE only when an operation is outstanding, results persist, RALU idles
   always @(negedge sysclk) begin
      if (sys_rst_n) begin
         if (DONE) begin
            chk("done_allowed", {63'h0, chk_valid}, 64'h1);
            chk("busy_in_done", {63'h0, BUSY}, 64'h0);
         end
         if (chk_valid && !BUSY) begin
            chk("res_hi", {48'h0, RES_HI_15_0}, {48'h0, exp_hi});
            chk("res_lo", {48'h0, RES_LO_15_0}, {48'h0, exp_lo});
            chk("err", {63'h0, ERR}, {63'h0, exp_err});
         end
         if (!BUSY) begin
            chk("idle_rn", {48'h0, RALU_RN_15_0}, 64'hFFFF);
            chk("idle_s", {48'h0, RALU_S_15_0}, {48'h0, RES_HI_15_0});
            chk("idle_ctl", {59'h0, RALU_RSN, RALU_ALUI4, RALU_CI, RALU_LOG, RALU_FSEL}, 64'h0);
         end
      end
   end

   // Issue one operation; called at posedge+1 with the DUT idle
   task automatic run_op(input string name, input logic op, input logic [15:0] h, l, m,
                         input int lat, input logic [32:0] lit, input bit inj_mid, input bit inj_done);
      logic [32:0] e;
      int          k;
      bit          seen;
      e = model(op, h, l, m);
      chk({name, "_model"}, {31'h0, e}, {31'h0, lit});
      START     = 1'b1;
      OP        = op;
      OPH_15_0  = h;
      OPL_15_0  = l;
      OPM_15_0  = m;
      chk_valid = 1'b0;
      @(posedge sysclk); #1;
      START = 1'b0;
      {exp_err, exp_hi, exp_lo} = lit;
      chk_valid = 1'b1;
      chk({name, "_busy"}, {63'h0, BUSY}, 64'h1);
      k    = 1;
      seen = 1'b0;
      while (!seen && k < 40) begin
         if (DONE) begin
            seen = 1'b1;
         end else begin
            if (inj_mid && k == 5) begin
               START    = 1'b1;
               OP       = ~op;
               OPH_15_0 = 16'hDEAD;
               OPL_15_0 = 16'hBEEF;
               OPM_15_0 = 16'h0007;
            end else begin
               START = 1'b0;
            end
            @(posedge sysclk); #1;
            k++;
         end
      end
      chk({name, "_latency"}, seen ? 64'(k) : 64'hFFFF, 64'(lat));
      if (inj_done && seen) begin
         START = 1'b1;
         OP    = ~op;
         @(posedge sysclk); #1;
         START = 1'b0;
         chk({name, "_ign_busy"}, {63'h0, BUSY}, 64'h0);
         chk({name, "_ign_done"}, {63'h0, DONE}, 64'h0);
      end else begin
         @(posedge sysclk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      sys_rst_n = 1'b0;
      #12;
      chk("rst_busy", {63'h0, BUSY}, 64'h0);
      chk("rst_done", {63'h0, DONE}, 64'h0);
      chk("rst_err", {63'h0, ERR}, 64'h0);
      chk("rst_hi", {48'h0, RES_HI_15_0}, 64'h0);
      chk("rst_lo", {48'h0, RES_LO_15_0}, 64'h0);
      chk("rst_rn", {48'h0, RALU_RN_15_0}, 64'hFFFF);
      @(posedge sysclk); #1;
      sys_rst_n = 1'b1;
      @(posedge sysclk); #1;

      run_op("mul_ffff", 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 17, {1'b0, 32'hFFFE0001}, 1'b0, 1'b0);
      run_op("mul_zero", 1'b0, 16'h0000, 16'h0000, 16'h1234, 17, {1'b0, 32'h00000000}, 1'b0, 1'b0);
      run_op("mul_ff",   1'b0, 16'h0000, 16'h0101, 16'h00FF, 17, {1'b0, 32'h0000FFFF}, 1'b0, 1'b0);
      run_op("div_3",    1'b1, 16'h0001, 16'h0000, 16'h0003, 18, {1'b0, 16'h0001, 16'h5555}, 1'b0, 1'b0);
      run_op("div_zero", 1'b1, 16'h1234, 16'h5678, 16'h0000, 2,  {1'b1, 16'h1234, 16'h5678}, 1'b0, 1'b0);
      run_op("div_ovf",  1'b1, 16'h0005, 16'h0000, 16'h0005, 2,  {1'b1, 16'h0005, 16'h0000}, 1'b0, 1'b0);
      run_op("div_big",  1'b1, 16'h7FFF, 16'hFFFF, 16'hFFFF, 18, {1'b0, 16'h7FFF, 16'h8000}, 1'b0, 1'b0);
      run_op("mul_inj",  1'b0, 16'h0000, 16'h0003, 16'hABCD, 17, {1'b0, 32'h00020367}, 1'b1, 1'b1);
      run_op("div_inj",  1'b1, 16'h0000, 16'h0064, 16'h0007, 18, {1'b0, 16'h0002, 16'h000E}, 1'b1, 1'b1);

      // Abort a multiply part-way through RUN with an asynchronous reset
      START     = 1'b1;
      OP        = 1'b0;
      OPH_15_0  = 16'h0000;
      OPL_15_0  = 16'h7777;
      OPM_15_0  = 16'h3333;
      chk_valid = 1'b0;
      @(posedge sysclk); #1;
      START = 1'b0;
      repeat (8) @(posedge sysclk);
      #2;
      sys_rst_n = 1'b0;
      #1;
      chk("abort_busy", {63'h0, BUSY}, 64'h0);
      chk("abort_done", {63'h0, DONE}, 64'h0);
      chk("abort_err", {63'h0, ERR}, 64'h0);
      chk("abort_hi", {48'h0, RES_HI_15_0}, 64'h0);
      chk("abort_lo", {48'h0, RES_LO_15_0}, 64'h0);
      repeat (3) begin
         @(posedge sysclk); #1;
         chk("abort_no_done", {63'h0, DONE}, 64'h0);
      end
      sys_rst_n = 1'b1;
      repeat (20) begin
         @(posedge sysclk); #1;
         chk("post_rst_idle", {62'h0, BUSY, DONE}, 64'h0);
      end

      run_op("mul_after_rst", 1'b0, 16'h0000, 16'h0010, 16'h1234, 17, {1'b0, 32'h00012340}, 1'b0, 1'b0);

      repeat (2) @(posedge sysclk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cga_alu_muldiv_seq.md
Name: cga_alu_muldiv_seq

Overview:
Multi-cycle sequencer that runs unsigned 16x16->32 multiply and 32/16 restoring divide by iterating the CPU RALU one bit per clock. It drives the RALU control inputs (ALUI4, CI, FSEL, LOG, RSN) and operands (RN, S), consumes F and CRY, and holds the partial-result registers. It sits beside the RALU in /CGA/ALU and is started by microcode through a start/busy/done handshake.

Parameters:
WIDTH, 16, operand width; fixed to the RALU width, no other value is supported
CNT_W, 5, step-counter width; must hold the value WIDTH

Ports:
sysclk  in  1  system clock, rising edge
sys_rst_n  in  1  asynchronous active-low reset
START  in  1  one-cycle request; sampled only in IDLE
OP  in  1  0=MUL, 1=DIV; sampled with START
OPH_15_0  in  16  DIV: dividend high word; ignored for MUL
OPL_15_0  in  16  MUL: multiplier; DIV: dividend low word
OPM_15_0  in  16  MUL: multiplicand; DIV: divisor
BUSY  out  1  high from the cycle after START is accepted until DONE
DONE  out  1  one-cycle pulse; results are valid in this cycle
ERR  out  1  DIV overflow or divide-by-zero; valid with DONE; held until next accepted START
RES_HI_15_0  out  16  A register: MUL product[31:16]; DIV remainder
RES_LO_15_0  out  16  Q register: MUL product[15:0]; DIV quotient
RALU_RN_15_0  out  16  R operand, negated (RN = ~R)
RALU_S_15_0  out  16  S operand
RALU_RSN, RALU_ALUI4, RALU_CI, RALU_LOG, RALU_FSEL  out  1 each  RALU controls
RALU_F_15_0  in  16  RALU function result
RALU_CRY  in  1  RALU carry out

Behaviour:
- Clocking and reset: one clock domain, sysclk. Reset is asynchronous and active-low on sys_rst_n. On reset: state=IDLE; A=0, Q=0, M=0, cnt=0; BUSY=0, DONE=0, ERR=0. Reset asserted mid-operation aborts immediately with no partial DONE.
- RALU encodings (combinational from state):
  - ADD (R+S): RSN=0, ALUI4=0, CI=0, LOG=0, FSEL=0.
  - SUB (S-R): RSN=1, ALUI4=0, CI=1, LOG=0, FSEL=0. CRY=1 means no borrow.
  - Outside CHECK/RUN: ADD encoding with RN=16'hFFFF and S=A.
- States:
  - IDLE: on START, load M=OPM, Q=OPL, A=(OP ? OPH : 0), cnt=0, latch op, clear ERR. MUL goes to RUN; DIV goes to CHECK. START while not IDLE is ignored.
  - CHECK (DIV only, 1 cycle): SUB with S=A, R=M. If CRY=1 (A>=M, which includes M=0), set ERR and go to DONE; A and Q are unchanged (they keep the dividend). Otherwise go to RUN.
  - RUN (WIDTH cycles, cnt 0..15):
    - MUL step: ADD with S=A, R=(Q[0] ? M : 0). Update A<={CRY,F[15:1]}, Q<={F[0],Q[15:1]}.
    - DIV step: Ash={A[14:0],Q[15]}, msb=A[15]. SUB with S=Ash, R=M. If msb|CRY: A<=F, Q<={Q[14:0],1}. Else: A<=Ash, Q<={Q[14:0],0}.
    - When cnt==WIDTH-1, go to DONE.
  - DONE (1 cycle): DONE=1, BUSY=0, then go to IDLE. A START in this cycle is ignored.
- Latency, counted from the START edge to the DONE cycle: MUL 17 cycles; DIV 18 cycles; DIV error 2 cycles.
- Results persist on RES_* until the next accepted START.
- All arithmetic is modulo 2^16 per RALU pass. The carry and msb logic extends each pass to 17 bits.

Decomposition:
- Package cga_alu_muldiv_pkg:
  - state enum (IDLE, CHECK, RUN, DONE)
  - OP_MUL/OP_DIV constants
  - RALU control-vector constants for ADD and SUB
- Sub-module cga_alu_muldiv_step: purely combinational. Inputs op, A, Q, M, F, CRY. Outputs the RALU R/S operands and the next A/Q. The FSM and registers stay in the top module.

Test Plan:
- MUL OPM=FFFF, OPL=FFFF -> DONE on cycle 17, RES_HI=FFFE, RES_LO=0001, ERR=0.
- MUL OPM=1234, OPL=0000 -> product 00000000; MUL 00FF x 0101 -> 0000FFFF.
- DIV OPH=0001, OPL=0000, OPM=0003 -> DONE on cycle 18, quotient 5555, remainder 0001, ERR=0.
- DIV OPM=0000 or OPH=0005/OPM=0005 -> DONE on cycle 2, ERR=1, RES_HI/LO keep the dividend.
- START pulsed mid-RUN and in the DONE cycle -> ignored; the result matches a single operation.
- sys_rst_n low at RUN cycle 8 -> BUSY=0, all outputs 0 asynchronously, no DONE; the next START runs a normal operation.
